pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the five-stage CPU: generalises the fixed 6-bit stall controller to STAGES stages. It merges per-stage stall requests with a multi-cycle hold channel for iterative units such as the divider, and a flush/redirect path. It derives per-stage bubble-insert strobes and keeps saturating stall and flush counters. It sits beside the pipeline and drives every stage register's stall/flush inputs.

## Interface
- STAGES, 6, number of controlled stages; bit 0 = PC/IF, bit STAGES-1 = WB
- PC_WIDTH, 32, width of redirect PC
- HOLD_W, 6, width of hold length
- CNT_WIDTH, 32, width of performance counters
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stallreq  in  STAGES  bit k = stage k requests stall of stages k..0 this cycle
- hold_start  in  1  start a multi-cycle hold
- hold_stage  in  $clog2(STAGES)  stage index for the hold
- hold_len  in  HOLD_W  total hold cycles, including the start cycle
- flush_req  in  1  redirect/exception flush request
- flush_pc  in  PC_WIDTH  redirect target
- stall  out  STAGES  bit i = 1: stage i holds its register
- bubble  out  STAGES  bit i = 1: stage i loads a bubble (nop)
- flush  out  1  flush all stages this cycle
- new_pc  out  PC_WIDTH  redirect target, valid when flush=1
- hold_busy  out  1  hold in progress beyond its start cycle
- stall_cnt  out  CNT_WIDTH  cycles with stall[0]=1 since reset, saturating
- flush_cnt  out  CNT_WIDTH  cycles with flush=1 since reset, saturating

## Operation
- Hold state: hold_cnt (HOLD_W), hold_stg (stage index). hold_busy = (hold_cnt != 0).
- Hold acceptance: hold_start & ~hold_busy & ~flush_req & ~rst & (hold_len != 0).
  - On acceptance: hold_stg <= hold_stage; hold_cnt <= hold_len-1.
  - hold_start while busy, during flush, during rst, or with hold_len=0 is ignored. No queueing.
- While hold_busy: hold_cnt decrements by 1 each cycle and reaches 0 after exactly hold_len total stalled cycles.
- hold_stage >= STAGES is clamped to STAGES-1.
- Effective stall index K = highest index among set stallreq bits, hold_stage (accepting cycle), and hold_stg (while busy). Simultaneous sources: the maximum wins.
- stall = bits K..0 set, all others 0. If no source is active, stall = 0.
- Flush priority: flush_req forces stall = 0 and bubble = 0, sets flush = 1 and new_pc = flush_pc, and clears hold_cnt at the edge.
- new_pc = 0 when flush = 0.
- bubble[0] = 0; bubble[i] = stall[i-1] & ~stall[i] for i >= 1.
  - At most one bubble bit is set.
  - No bubble bit is set when K = STAGES-1.
- Counters: stall_cnt += stall[0]; flush_cnt += flush. Each holds at all-ones (no wrap).
- rst: stall, bubble, flush, new_pc forced 0 combinationally. At the edge, hold_cnt, hold_stg, stall_cnt and flush_cnt are cleared. rst dominates all inputs, including mid-hold.

## Timing
- stall, bubble, flush, new_pc: combinational from inputs and registered hold state, zero latency. The requester sees the stall in the same cycle it raises stallreq or hold_start.
- hold_busy: registered. Accepted hold_start at cycle t with length L:
  - stall asserted at cycles t..t+L-1
  - hold_busy = 1 at t+1..t+L-1
  - idle at t+L, when a new hold_start is accepted
- L = 1 stalls only cycle t; hold_busy never rises.
- Flush at cycle f during a hold: stall = 0 at f, and hold_busy = 0 from f+1.
- Counters are registered: an event at cycle t is visible at t+1.
- Reset values of every output: stall 0, bubble 0, flush 0, new_pc 0, hold_busy 0, stall_cnt 0, flush_cnt 0.

## Test plan
- STAGES=6, stallreq=6'b001000 -> stall=6'b001111, bubble=6'b010000, flush=0.
- stallreq=6'b000100 and hold_start with hold_stage=3, hold_len=1 in the same cycle -> stall=6'b001111 that cycle only, hold_busy stays 0.
- hold_start, hold_stage=3, hold_len=4 at t, stallreq=0 -> stall=6'b001111 at t..t+3, hold_busy=1 at t+1..t+3, stall=0 at t+4; a second hold_start at t+2 is ignored.
- Same hold, flush_req at t+1 with flush_pc=32'hBFC00380 -> at t+1: flush=1, new_pc=32'hBFC00380, stall=0, bubble=0; at t+2: hold_busy=0, flush_cnt incremented by 1.
- CNT_WIDTH=4, stallreq[1] held for 20 cycles -> stall_cnt reaches 15 and stays 15.
- rst asserted at t+2 of a 5-cycle hold -> stall=0 at t+2; at t+3: hold_busy=0, stall_cnt=0, flush_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall/hold/flush requests from the pipeline and
// the per-stage stall/bubble/flush controls plus counters sent back to it.
interface pipe_ctrl_if #(
  parameter int STAGES    = 6,
  parameter int PC_WIDTH  = 32,
  parameter int HOLD_W    = 6,
  parameter int CNT_WIDTH = 32
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [STAGES-1:0]    stallreq;
  logic                 hold_start;
  logic [SW-1:0]        hold_stage;
  logic [HOLD_W-1:0]    hold_len;
  logic                 flush_req;
  logic [PC_WIDTH-1:0]  flush_pc;
  logic [STAGES-1:0]    stall;
  logic [STAGES-1:0]    bubble;
  logic                 flush;
  logic [PC_WIDTH-1:0]  new_pc;
  logic                 hold_busy;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output stallreq, hold_start, hold_stage, hold_len, flush_req, flush_pc,
    input  stall, bubble, flush, new_pc, hold_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  stallreq, hold_start, hold_stage, hold_len, flush_req, flush_pc,
    output stall, bubble, flush, new_pc, hold_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stall requests, a multi-cycle hold
// channel and a flush path into per-stage stall/bubble strobes plus counters.
module pipe_ctrl #(
  parameter int STAGES    = 6,
  parameter int PC_WIDTH  = 32,
  parameter int HOLD_W    = 6,
  parameter int CNT_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SW-1:0]        LAST_STG = SW'(STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]        hold_stg_q, hold_stg_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic                 hold_busy_s;
  logic                 accept_s;
  logic                 hold_act_s;
  logic [SW-1:0]        start_stg_s;
  logic [SW-1:0]        hold_idx_s;
  logic                 run_s;
  logic [STAGES-1:0]    stall_raw_s;
  logic [STAGES-1:0]    stall_s;
  logic [STAGES-1:0]    bubble_s;
  logic                 flush_s;
  logic [PC_WIDTH-1:0]  new_pc_s;

  // Hold acceptance and the stage index the hold channel currently claims
  always_comb begin
    if (bus.hold_stage > LAST_STG) begin
      start_stg_s = LAST_STG;
    end else begin
      start_stg_s = bus.hold_stage;
    end
    hold_busy_s = (hold_cnt_q != HOLD_W'(0));
    accept_s    = bus.hold_start & ~hold_busy_s & ~bus.flush_req & ~rst
                  & (bus.hold_len != HOLD_W'(0));
    hold_act_s  = accept_s | hold_busy_s;
    if (hold_busy_s) begin
      hold_idx_s = hold_stg_q;
    end else begin
      hold_idx_s = start_stg_s;
    end
  end

  // Stall mask: a request at stage k stalls k..0, so scan from the top down
  always_comb begin
    run_s       = 1'b0;
    stall_raw_s = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      run_s          = run_s | bus.stallreq[i];
      stall_raw_s[i] = run_s | (hold_act_s & (SW'(i) <= hold_idx_s));
    end
    if (rst | bus.flush_req) begin
      stall_s = {STAGES{1'b0}};
    end else begin
      stall_s = stall_raw_s;
    end
    bubble_s    = {STAGES{1'b0}};
    for (int i = 1; i < STAGES; i++) begin
      bubble_s[i] = stall_s[i-1] & ~stall_s[i];
    end
    flush_s = bus.flush_req & ~rst;
    if (flush_s) begin
      new_pc_s = bus.flush_pc;
    end else begin
      new_pc_s = {PC_WIDTH{1'b0}};
    end
  end

  // Next-state for hold tracking and saturating event counters
  always_comb begin
    if (bus.flush_req) begin
      hold_cnt_d = HOLD_W'(0);
    end else if (accept_s) begin
      hold_cnt_d = bus.hold_len - HOLD_W'(1);
    end else if (hold_busy_s) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
    if (accept_s) begin
      hold_stg_d = start_stg_s;
    end else begin
      hold_stg_d = hold_stg_q;
    end
    if (stall_s[0] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q  <= HOLD_W'(0);
      hold_stg_q  <= SW'(0);
      stall_cnt_q <= CNT_WIDTH'(0);
      flush_cnt_q <= CNT_WIDTH'(0);
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      hold_stg_q  <= hold_stg_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.bubble    = bubble_s;
  assign bus.flush     = flush_s;
  assign bus.new_pc    = new_pc_s;
  assign bus.hold_busy = hold_busy_s;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus multi-cycle hold,
// flush and reset sequences, checked through a scoreboard queue.
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  logic rst2;

  pipe_ctrl_if #(.STAGES(6), .PC_WIDTH(32), .HOLD_W(6), .CNT_WIDTH(32)) b ();
  pipe_ctrl_if #(.STAGES(6), .PC_WIDTH(32), .HOLD_W(6), .CNT_WIDTH(4))  b2 ();

  pipe_ctrl #(.STAGES(6), .PC_WIDTH(32), .HOLD_W(6), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .bus(b.slave));
  pipe_ctrl #(.STAGES(6), .PC_WIDTH(32), .HOLD_W(6), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst2), .bus(b2.slave));

  typedef struct {
    logic        rst;
    logic [5:0]  sreq;
    logic        hs;
    logic [2:0]  hstg;
    logic [5:0]  hlen;
    logic        fr;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic [5:0]  e_bub;
    logic        e_fl;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t  tbl[13];
  vec_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_flush_cnt = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [5:0] sreq, input logic hs,
                              input logic [2:0] hstg, input logic [5:0] hlen,
                              input logic fr, input logic [31:0] fpc,
                              input logic [5:0] es, input logic [5:0] eb,
                              input logic ebusy);
    vec_t v;
    v.rst = r; v.sreq = sreq; v.hs = hs; v.hstg = hstg; v.hlen = hlen;
    v.fr = fr; v.fpc = fpc; v.e_stall = es; v.e_bub = eb; v.e_busy = ebusy;
    v.e_fl = fr & ~r;
    v.e_pc = v.e_fl ? fpc : 32'd0;
    return v;
  endfunction

  function automatic vec_t idle(input logic [5:0] es, input logic [5:0] eb, input logic ebusy);
    return mk(1'b0, 6'd0, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0, es, eb, ebusy);
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst          = v.rst;
    b.stallreq   = v.sreq;
    b.hold_start = v.hs;
    b.hold_stage = v.hstg;
    b.hold_len   = v.hlen;
    b.flush_req  = v.fr;
    b.flush_pc   = v.fpc;
    sb.push_back(v);
  endtask

  // Scoreboard: pop the expectation for this cycle and compare mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("stall",     64'(b.stall),     64'(e.e_stall));
      chk("bubble",    64'(b.bubble),    64'(e.e_bub));
      chk("flush",     64'(b.flush),     64'(e.e_fl));
      chk("new_pc",    64'(b.new_pc),    64'(e.e_pc));
      chk("hold_busy", 64'(b.hold_busy), 64'(e.e_busy));
      chk("stall_cnt", 64'(b.stall_cnt), 64'(m_stall_cnt));
      chk("flush_cnt", 64'(b.flush_cnt), 64'(m_flush_cnt));
      if (e.rst) begin
        m_stall_cnt = 32'd0;
        m_flush_cnt = 32'd0;
      end else begin
        if (e.e_stall[0]) m_stall_cnt = m_stall_cnt + 32'd1;
        if (e.e_fl)       m_flush_cnt = m_flush_cnt + 32'd1;
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    b.stallreq = 6'd0; b.hold_start = 1'b0; b.hold_stage = 3'd0;
    b.hold_len = 6'd0; b.flush_req = 1'b0; b.flush_pc = 32'd0;
    b2.stallreq = 6'd0; b2.hold_start = 1'b0; b2.hold_stage = 3'd0;
    b2.hold_len = 6'd0; b2.flush_req = 1'b0; b2.flush_pc = 32'd0;

    tbl[0]  = mk(1'b1, 6'b111111, 1'b1, 3'd3, 6'd4, 1'b1, 32'hDEADBEEF, 6'b000000, 6'b000000, 1'b0);
    tbl[1]  = mk(1'b0, 6'b001000, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0,        6'b001111, 6'b010000, 1'b0);
    tbl[2]  = mk(1'b0, 6'b000001, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0,        6'b000001, 6'b000010, 1'b0);
    tbl[3]  = mk(1'b0, 6'b100000, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0,        6'b111111, 6'b000000, 1'b0);
    tbl[4]  = mk(1'b0, 6'b010010, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0,        6'b011111, 6'b100000, 1'b0);
    tbl[5]  = idle(6'b000000, 6'b000000, 1'b0);
    tbl[6]  = mk(1'b0, 6'b111111, 1'b0, 3'd0, 6'd0, 1'b1, 32'h12345678, 6'b000000, 6'b000000, 1'b0);
    tbl[7]  = mk(1'b0, 6'b000100, 1'b1, 3'd3, 6'd1, 1'b0, 32'd0,        6'b001111, 6'b010000, 1'b0);
    tbl[8]  = idle(6'b000000, 6'b000000, 1'b0);
    tbl[9]  = mk(1'b0, 6'b000000, 1'b1, 3'd7, 6'd1, 1'b0, 32'd0,        6'b111111, 6'b000000, 1'b0);
    tbl[10] = mk(1'b0, 6'b000000, 1'b1, 3'd3, 6'd0, 1'b0, 32'd0,        6'b000000, 6'b000000, 1'b0);
    tbl[11] = mk(1'b0, 6'b000000, 1'b1, 3'd2, 6'd1, 1'b1, 32'hBFC00380, 6'b000000, 6'b000000, 1'b0);
    tbl[12] = idle(6'b000000, 6'b000000, 1'b0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 13; i++) apply(tbl[i]);

    // Hold of 4 on stage 3; overlapping start ignored; new hold accepted at t+4
    apply(mk(1'b0, 6'd0, 1'b1, 3'd3, 6'd4, 1'b0, 32'd0, 6'b001111, 6'b010000, 1'b0));
    apply(idle(6'b001111, 6'b010000, 1'b1));
    apply(mk(1'b0, 6'd0, 1'b1, 3'd5, 6'd3, 1'b0, 32'd0, 6'b001111, 6'b010000, 1'b1));
    apply(idle(6'b001111, 6'b010000, 1'b1));
    apply(mk(1'b0, 6'd0, 1'b1, 3'd1, 6'd2, 1'b0, 32'd0, 6'b000011, 6'b000100, 1'b0));
    apply(idle(6'b000011, 6'b000100, 1'b1));
    apply(idle(6'b000000, 6'b000000, 1'b0));

    // Flush one cycle into a hold
    apply(mk(1'b0, 6'd0, 1'b1, 3'd3, 6'd4, 1'b0, 32'd0, 6'b001111, 6'b010000, 1'b0));
    apply(mk(1'b0, 6'd0, 1'b0, 3'd0, 6'd0, 1'b1, 32'hBFC00380, 6'b000000, 6'b000000, 1'b1));
    apply(idle(6'b000000, 6'b000000, 1'b0));

    // Hold on stage 2 merged with higher and lower stall requests
    apply(mk(1'b0, 6'd0, 1'b1, 3'd2, 6'd3, 1'b0, 32'd0, 6'b000111, 6'b001000, 1'b0));
    apply(mk(1'b0, 6'b010000, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0, 6'b011111, 6'b100000, 1'b1));
    apply(mk(1'b0, 6'b000001, 1'b0, 3'd0, 6'd0, 1'b0, 32'd0, 6'b000111, 6'b001000, 1'b1));
    apply(idle(6'b000000, 6'b000000, 1'b0));

    // Reset at t+2 of a 5-cycle hold dominates requests and a new hold_start
    apply(mk(1'b0, 6'd0, 1'b1, 3'd4, 6'd5, 1'b0, 32'd0, 6'b011111, 6'b100000, 1'b0));
    apply(idle(6'b011111, 6'b100000, 1'b1));
    apply(mk(1'b1, 6'b111111, 1'b1, 3'd2, 6'd3, 1'b0, 32'd0, 6'b000000, 6'b000000, 1'b1));
    apply(idle(6'b000000, 6'b000000, 1'b0));
    apply(idle(6'b000000, 6'b000000, 1'b0));

    @(posedge clk);
    #1;
    rst = 1'b0; b.stallreq = 6'd0; b.hold_start = 1'b0; b.flush_req = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Narrow counter saturates at 15 with stallreq[1] held for 20 cycles
    @(posedge clk); #1; rst2 = 1'b1;
    @(posedge clk); #1; rst2 = 1'b0; b2.stallreq = 6'b000010;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("sat_stall", 64'(b2.stall), 64'h3);
      chk("sat_cnt", 64'(b2.stall_cnt), (k < 15) ? 64'(k) : 64'd15);
      @(posedge clk); #1;
    end
    b2.stallreq = 6'd0;
    @(negedge clk);
    chk("sat_cnt_hold", 64'(b2.stall_cnt), 64'd15);
    chk("sat_flush_cnt", 64'(b2.flush_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
